// File: rtl/parking_gate_ctrl_if.sv
// Parking gate controller bus: groups the sensor/keypad inputs and the status
// outputs of parking_gate_ctrl into one bundle.
//   slave  modport : controller side (sensors/keypad in, status out)
//   master modport : environment side (drives sensors/keypad, observes status)
interface parking_gate_ctrl_if #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned PW_W  = 4
);
  logic             entry_sensor;
  logic             exit_sensor;
  logic             pw_valid;
  logic [PW_W-1:0]  pw_data;
  logic             car_passed;
  logic             gate_open;
  logic             green_led;
  logic             red_led;
  logic             lockout;
  logic             full;
  logic [CNT_W-1:0] occupied;
  logic [CNT_W-1:0] available;
  logic [2:0]       state_code;
  logic [15:0]      entry_count;

  modport slave (
    input  entry_sensor, exit_sensor, pw_valid, pw_data, car_passed,
    output gate_open, green_led, red_led, lockout, full, occupied, available,
           state_code, entry_count
  );

  modport master (
    output entry_sensor, exit_sensor, pw_valid, pw_data, car_passed,
    input  gate_open, green_led, red_led, lockout, full, occupied, available,
           state_code, entry_count
  );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Parking entry gate controller: password-protected entry with retry lockout,
// occupancy tracking and a running count of committed entries.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : parking_gate_ctrl_if.slave
//          in : entry_sensor (level), exit_sensor (pulse), pw_valid/pw_data,
//               car_passed (pulse)
//          out: gate_open, green_led, red_led, lockout, full, occupied,
//               available, state_code, entry_count
module parking_gate_ctrl #(
  parameter int unsigned    CAPACITY    = 8,
  parameter int unsigned    CNT_W       = 4,
  parameter int unsigned    PW_W        = 4,
  parameter logic [PW_W-1:0] PASSWORD   = PW_W'(5),
  parameter int unsigned    WAIT_CYCLES = 8,
  parameter int unsigned    MAX_TRIES   = 3,
  parameter int unsigned    LOCK_CYCLES = 16
) (
  input logic                  clk,
  input logic                  rst,
  parking_gate_ctrl_if.slave   bus
);

  localparam int unsigned WaitW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned LockW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int unsigned TryW  = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitPw  = 3'd1,
    StGranted = 3'd2,
    StDenied  = 3'd3,
    StLocked  = 3'd4
  } state_e;

  state_e           state_q;
  logic [WaitW-1:0] wait_tmr_q;
  logic [LockW-1:0] lock_tmr_q;
  logic [TryW-1:0]  tries_q;
  logic [CNT_W-1:0] occupied_q, occupied_d;
  logic [15:0]      entry_count_q;
  logic             gate_open_q, green_q, red_q, lockout_q;

  logic full;
  logic commit;
  logic exit_ok;

  assign full    = (occupied_q == CNT_W'(CAPACITY));
  assign commit  = (state_q == StGranted) && bus.car_passed;
  assign exit_ok = bus.exit_sensor && (occupied_q != '0);

  // Entry and exit in the same cycle cancel; a commit while full only counts.
  always_comb begin
    occupied_d = occupied_q;
    if (commit && !exit_ok) begin
      if (!full) occupied_d = occupied_q + CNT_W'(1);
    end else if (!commit && exit_ok) begin
      occupied_d = occupied_q - CNT_W'(1);
    end
  end

  // Outputs are registered alongside the state: each branch writes the values
  // that belong to the state being entered, defaults cover everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      wait_tmr_q    <= '0;
      lock_tmr_q    <= '0;
      tries_q       <= '0;
      occupied_q    <= '0;
      entry_count_q <= '0;
      gate_open_q   <= 1'b0;
      green_q       <= 1'b0;
      red_q         <= 1'b0;
      lockout_q     <= 1'b0;
    end else begin
      occupied_q    <= occupied_d;
      entry_count_q <= entry_count_q + 16'(commit);
      gate_open_q   <= 1'b0;
      green_q       <= 1'b0;
      red_q         <= 1'b0;
      lockout_q     <= 1'b0;

      case (state_q)
        StIdle: begin
          if (bus.entry_sensor && !full) begin
            state_q    <= StWaitPw;
            wait_tmr_q <= '0;
            green_q    <= 1'b1;
          end else if (bus.entry_sensor) begin
            red_q <= 1'b1;
          end
        end

        StWaitPw: begin
          if (!bus.entry_sensor) begin
            // Car left: abort takes priority over any code this cycle.
            state_q <= StIdle;
            tries_q <= '0;
          end else if (bus.pw_valid) begin
            if (bus.pw_data == PASSWORD) begin
              state_q     <= StGranted;
              tries_q     <= '0;
              gate_open_q <= 1'b1;
              green_q     <= 1'b1;
            end else if (tries_q + TryW'(1) == TryW'(MAX_TRIES)) begin
              state_q    <= StLocked;
              tries_q    <= tries_q + TryW'(1);
              lock_tmr_q <= '0;
              lockout_q  <= 1'b1;
              red_q      <= 1'b1;
            end else begin
              state_q <= StDenied;
              tries_q <= tries_q + TryW'(1);
              red_q   <= 1'b1;
            end
          end else if (wait_tmr_q == WaitW'(WAIT_CYCLES - 1)) begin
            state_q <= StIdle;
            tries_q <= '0;
          end else begin
            wait_tmr_q <= wait_tmr_q + WaitW'(1);
            green_q    <= !green_q;
          end
        end

        StDenied: begin
          state_q    <= StWaitPw;
          wait_tmr_q <= '0;
          green_q    <= 1'b1;
        end

        StGranted: begin
          if (bus.car_passed || !bus.entry_sensor) begin
            state_q <= StIdle;
          end else begin
            gate_open_q <= 1'b1;
            green_q     <= 1'b1;
          end
        end

        StLocked: begin
          if (lock_tmr_q == LockW'(LOCK_CYCLES - 1)) begin
            state_q <= StIdle;
            tries_q <= '0;
          end else begin
            lock_tmr_q <= lock_tmr_q + LockW'(1);
            lockout_q  <= 1'b1;
            red_q      <= !red_q;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gate_open   = gate_open_q;
  assign bus.green_led   = green_q;
  assign bus.red_led     = red_q;
  assign bus.lockout     = lockout_q;
  assign bus.full        = full;
  assign bus.occupied    = occupied_q;
  assign bus.available   = CNT_W'(CAPACITY) - occupied_q;
  assign bus.state_code  = state_q;
  assign bus.entry_count = entry_count_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: directed scenarios plus random
// stimulus, every cycle compared against a behavioural reference model.
module tb_parking_gate_ctrl;

  localparam int          CAP   = 8;
  localparam int          WAITC = 8;
  localparam int          MAXT  = 3;
  localparam int          LOCKC = 16;
  localparam logic [3:0]  PASS  = 4'h5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parking_gate_ctrl_if #(.CNT_W(4), .PW_W(4)) bus ();

  parking_gate_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase uses the published state_code numbering, age counts
  // cycles spent in the current phase; LED blink derives from age parity.
  int m_phase, m_age, m_wrong, m_occ, m_cnt;
  bit m_redfull;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit es, input bit xs, input bit pv,
                            input logic [3:0] pd, input bit cp);
    int nxt;
    int n;
    bit commit, exit_ok;
    if (r) begin
      m_phase = 0; m_age = 0; m_wrong = 0; m_occ = 0; m_cnt = 0; m_redfull = 0;
      return;
    end
    commit    = (m_phase == 2) && cp;
    exit_ok   = xs && (m_occ > 0);
    nxt       = m_phase;
    m_redfull = 0;
    case (m_phase)
      0: if (es && m_occ != CAP) nxt = 1; else if (es) m_redfull = 1;
      1: begin
        if (!es) begin nxt = 0; m_wrong = 0; end
        else if (pv) begin
          if (pd == PASS) begin nxt = 2; m_wrong = 0; end
          else begin m_wrong++; nxt = (m_wrong == MAXT) ? 4 : 3; end
        end else if (m_age == WAITC - 1) begin nxt = 0; m_wrong = 0; end
      end
      2: if (cp || !es) nxt = 0;
      3: nxt = 1;
      4: if (m_age == LOCKC - 1) begin nxt = 0; m_wrong = 0; end
      default: nxt = 0;
    endcase
    m_age   = (nxt == m_phase) ? m_age + 1 : 0;
    m_phase = nxt;
    n = m_occ + int'(commit) - int'(exit_ok);
    m_occ = (n > CAP) ? CAP : n;
    m_cnt = (m_cnt + int'(commit)) % 65536;
  endtask

  task automatic compare_all();
    check_eq("state_code", 32'(bus.state_code), 32'(m_phase));
    check_eq("gate_open", 32'(bus.gate_open), 32'(m_phase == 2));
    check_eq("green_led", 32'(bus.green_led),
             32'(m_phase == 2 || (m_phase == 1 && m_age % 2 == 0)));
    check_eq("red_led", 32'(bus.red_led),
             32'(m_phase == 3 || (m_phase == 4 && m_age % 2 == 0) ||
                 (m_phase == 0 && m_redfull)));
    check_eq("lockout", 32'(bus.lockout), 32'(m_phase == 4));
    check_eq("full", 32'(bus.full), 32'(m_occ == CAP));
    check_eq("occupied", 32'(bus.occupied), 32'(m_occ));
    check_eq("available", 32'(bus.available), 32'(CAP - m_occ));
    check_eq("entry_count", 32'(bus.entry_count), 32'(m_cnt));
  endtask

  task automatic cycle(input bit r, input bit es, input bit xs, input bit pv,
                       input logic [3:0] pd, input bit cp);
    rst              = r;
    bus.entry_sensor = es;
    bus.exit_sensor  = xs;
    bus.pw_valid     = pv;
    bus.pw_data      = pd;
    bus.car_passed   = cp;
    @(posedge clk);
    model_step(r, es, xs, pv, pd, cp);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b1, 1'b1, 1'b1, PASS, 1'b1);  // inputs must be ignored
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_state"}, 32'(bus.state_code), 32'd0);
    check_eq({tag, "_gate"}, 32'(bus.gate_open), 32'd0);
    check_eq({tag, "_leds"}, 32'({bus.green_led, bus.red_led}), 32'd0);
    check_eq({tag, "_lockout"}, 32'(bus.lockout), 32'd0);
    check_eq({tag, "_occ"}, 32'(bus.occupied), 32'd0);
    check_eq({tag, "_avail"}, 32'(bus.available), 32'(CAP));
    check_eq({tag, "_full"}, 32'(bus.full), 32'd0);
    check_eq({tag, "_cnt"}, 32'(bus.entry_count), 32'd0);
  endtask

  task automatic enter_grant();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, PASS, 1'b0);
  endtask

  task automatic do_entry();
    enter_grant();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic do_exit();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic to_lockout();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < MAXT; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'h2, 1'b0);
      if (i < MAXT - 1) begin
        check_eq("denied_state", 32'(bus.state_code), 32'd3);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      end
    end
    check_eq("locked_state", 32'(bus.state_code), 32'd4);
    check_eq("locked_flag", 32'(bus.lockout), 32'd1);
  endtask

  initial begin
    bit es_r;
    rst = 1'b1;
    bus.entry_sensor = 1'b0; bus.exit_sensor = 1'b0; bus.pw_valid = 1'b0;
    bus.pw_data = 4'h0; bus.car_passed = 1'b0;

    // Reset state
    do_reset();
    check_reset_vals("rst");

    // Happy path: code at cycle 3, car passes two cycles later
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, PASS, 1'b0);
    check_eq("happy_gate", 32'(bus.gate_open), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1);
    check_eq("happy_occ", 32'(bus.occupied), 32'd1);
    check_eq("happy_avail", 32'(bus.available), 32'd7);
    check_eq("happy_cnt", 32'(bus.entry_count), 32'd1);
    check_eq("happy_state", 32'(bus.state_code), 32'd0);

    // Lockout: correct code during lock is ignored, then back to idle
    do_reset();
    to_lockout();
    for (int i = 0; i < LOCKC - 1; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, PASS, 1'b0);
    check_eq("lock_hold", 32'(bus.state_code), 32'd4);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, PASS, 1'b0);
    check_eq("lock_release", 32'(bus.state_code), 32'd0);

    // Fill to capacity, refused entry, one exit
    do_reset();
    repeat (CAP) do_entry();
    check_eq("fill_full", 32'(bus.full), 32'd1);
    check_eq("fill_avail", 32'(bus.available), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    check_eq("fill_idle", 32'(bus.state_code), 32'd0);
    check_eq("fill_red", 32'(bus.red_led), 32'd1);
    do_exit();
    check_eq("fill_exit_full", 32'(bus.full), 32'd0);
    check_eq("fill_exit_occ", 32'(bus.occupied), 32'd7);

    // Simultaneous commit and exit; exit while empty
    do_reset();
    repeat (3) do_entry();
    enter_grant();
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    check_eq("simul_occ", 32'(bus.occupied), 32'd3);
    check_eq("simul_cnt", 32'(bus.entry_count), 32'd4);
    repeat (4) do_exit();
    check_eq("empty_exit", 32'(bus.occupied), 32'd0);

    // Timeout and abort in GRANTED
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    repeat (WAITC - 1) cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    check_eq("wait_hold", 32'(bus.state_code), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    check_eq("wait_timeout", 32'(bus.state_code), 32'd0);
    do_reset();
    do_entry();
    enter_grant();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    check_eq("abort_state", 32'(bus.state_code), 32'd0);
    check_eq("abort_occ", 32'(bus.occupied), 32'd1);

    // Reset mid-operation
    enter_grant();
    do_reset();
    check_reset_vals("rst_granted");
    to_lockout();
    do_reset();
    check_reset_vals("rst_locked");

    // Random traffic
    es_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      bit pv, cp, xs, r;
      logic [3:0] pd;
      if ($urandom_range(0, 7) == 0) es_r = ~es_r;
      pv = ($urandom_range(0, 3) == 0);
      pd = ($urandom_range(0, 1) == 1) ? PASS : 4'($urandom_range(0, 15));
      cp = ($urandom_range(0, 3) == 0);
      xs = ($urandom_range(0, 11) == 0);
      r  = ($urandom_range(0, 399) == 0);
      cycle(r, es_r, xs, pv, pd, cp);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
